// File: rtl/signal_capture_pkg.sv
// Shared signal-chain constants: signal generator settings and
// capture buffer defaults and state encoding.
package signal_capture_pkg;

    localparam int SIGGEN_NB_PHASE = 16;
    localparam int SIGGEN_NB_AMP   = 8;
    localparam int SIGGEN_N_TONES  = 4;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_ADDR_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

endpackage

// File: rtl/signal_capture_if.sv
// Port bundle between the capture controller and its sample buffer.
// One write port and one registered read port.
interface capture_mem_if #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 10
) ();
    logic               we;
    logic [NB_ADDR-1:0] waddr;
    logic [NB_DATA-1:0] wdata;
    logic [NB_ADDR-1:0] raddr;
    logic [NB_DATA-1:0] rdata;

    modport master (
        output we, waddr, wdata, raddr,
        input  rdata
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        output rdata
    );
endinterface

// File: rtl/signal_capture_bram.sv
// Simple dual-port sample buffer, read-first, registered read.
// Array is never reset so contents survive a controller reset.
module capture_bram #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    capture_mem_if.slave  mem_if
);
    localparam int DEPTH = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [NB_DATA-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (mem_if.we) begin
            mem[mem_if.waddr] <= mem_if.wdata;
        end
    end

    // Non-blocking read of the old word gives read-first behaviour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[mem_if.raddr];
        end
    end

    assign mem_if.rdata = rdata_q;

endmodule

// File: rtl/signal_capture.sv
// Capture controller: immediate or zero-crossing trigger, fills the
// sample buffer until full or stopped, readout in any state.
module signal_capture
    import signal_capture_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_trig_mode,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_ADDR:0]   o_count
);
    localparam logic [NB_ADDR:0] FULL = (NB_ADDR + 1)'(2 ** NB_ADDR);

    cap_state_e         state_q, state_d;
    logic [NB_ADDR:0]   count_q, count_d;
    logic [NB_DATA-1:0] prev_q, prev_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               we;
    logic [NB_ADDR-1:0] waddr;
    logic               crossing;

    capture_mem_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) mem_if ();

    assign crossing = i_valid && prev_q[NB_DATA-1] && !i_data[NB_DATA-1];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prev_d  = i_valid ? i_data : prev_q;
        we      = 1'b0;
        waddr   = count_q[NB_ADDR-1:0];
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    count_d = '0;
                    state_d = i_trig_mode ? ST_ARMED : ST_CAPTURE;
                end
            end
            ST_ARMED: begin
                if (i_stop) begin
                    state_d = ST_DONE;
                end else if (crossing) begin
                    we      = 1'b1;
                    waddr   = '0;
                    count_d = (NB_ADDR + 1)'(1);
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (i_valid) begin
                    we      = 1'b1;
                    count_d = count_q + 1'b1;
                end
                // A write that fills the buffer ends the capture at once
                if (i_stop || count_d == FULL) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            prev_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prev_q  <= prev_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_if.we    = we;
    assign mem_if.waddr = waddr;
    assign mem_if.wdata = i_data;
    assign mem_if.raddr = i_rd_addr;

    capture_bram #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_bram (
        .clk    (i_clock),
        .rst_n  (i_reset),
        .mem_if (mem_if.slave)
    );

    assign o_rd_data = mem_if.rdata;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_count   = count_q;

endmodule

// File: tb/tb_signal_capture.sv
// Directed bench for signal_capture with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_signal_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       trig = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = '0;
    logic [9:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic [10:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signal_capture #(.NB_DATA(8), .NB_ADDR(10)) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_stop      (stop),
        .i_trig_mode (trig),
        .i_valid     (valid),
        .i_data      (data),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_busy      (busy),
        .o_done      (done),
        .o_count     (count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic mode);
        trig  = mode;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [9:0] a,
                            input logic [7:0] exp);
        rd_addr = a;
        step();
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    logic [7:0] xing [5];

    initial begin
        xing[0] = 8'hFD; xing[1] = 8'hFF; xing[2] = 8'h02;
        xing[3] = 8'h05; xing[4] = 8'hFC;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rdata", 32'(rd_data), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Immediate full capture
        pulse_start(1'b0);
        chk("a_busy", 32'(busy), 32'd1);
        chk("a_count0", 32'(count), 32'd0);
        for (int i = 0; i < 1024; i++) begin
            valid = 1'b1;
            data  = 8'(i);
            step();
        end
        valid = 1'b0;
        chk("a_done", 32'(done), 32'd1);
        chk("a_busy_lo", 32'(busy), 32'd0);
        chk("a_count", 32'(count), 32'd1024);
        read_chk("a_rd5", 10'd5, 8'h05);
        read_chk("a_rd1023", 10'd1023, 8'hFF);
        valid = 1'b1;
        data  = 8'hAA;
        step();
        valid = 1'b0;
        read_chk("a_nowrap", 10'd0, 8'h00);
        chk("a_count_hold", 32'(count), 32'd1024);

        // Early stop with a same-cycle sample
        pulse_start(1'b0);
        for (int i = 0; i < 10; i++) begin
            valid = 1'b1;
            data  = 8'h40 + 8'(i);
            step();
        end
        stop = 1'b1;
        data = 8'h7F;
        step();
        stop  = 1'b0;
        valid = 1'b0;
        chk("b_count", 32'(count), 32'd11);
        chk("b_done", 32'(done), 32'd1);
        read_chk("b_rd10", 10'd10, 8'h7F);
        read_chk("b_rd9", 10'd9, 8'h49);

        // Zero-crossing trigger
        pulse_start(1'b1);
        chk("c_armed_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            data  = xing[i];
            step();
            if (i == 1) chk("c_no_trig", 32'(count), 32'd0);
        end
        valid = 1'b0;
        chk("c_count", 32'(count), 32'd3);
        pulse_start(1'b0);
        chk("c_start_ign", 32'(count), 32'd3);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("c_stop_prio", 32'(done), 32'd1);
        chk("c_count_keep", 32'(count), 32'd3);
        read_chk("c_rd0", 10'd0, 8'h02);
        read_chk("c_rd1", 10'd1, 8'h05);
        read_chk("c_rd2", 10'd2, 8'hFC);

        // Start-cycle sample is not stored
        trig  = 1'b0;
        start = 1'b1;
        valid = 1'b1;
        data  = 8'h11;
        step();
        start = 1'b0;
        data  = 8'h22;
        step();
        valid = 1'b0;
        chk("d_count", 32'(count), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        read_chk("d_rd0", 10'd0, 8'h22);

        // Restart from DONE, read-first collision, then reset mid-run
        pulse_start(1'b0);
        chk("e_count0", 32'(count), 32'd0);
        chk("e_done_lo", 32'(done), 32'd0);
        chk("e_busy", 32'(busy), 32'd1);
        rd_addr = 10'd5;
        for (int i = 0; i < 20; i++) begin
            valid = 1'b1;
            data  = 8'h80 + 8'(i);
            step();
            if (i == 5) chk("e_rd_first", 32'(rd_data), 32'h45);
            if (i == 6) chk("e_rd_new", 32'(rd_data), 32'h85);
        end
        chk("e_count", 32'(count), 32'd20);
        data = 8'h55;
        #2 rst_n = 1'b0;
        #1;
        chk("f_busy", 32'(busy), 32'd0);
        chk("f_done", 32'(done), 32'd0);
        chk("f_count", 32'(count), 32'd0);
        chk("f_rdata", 32'(rd_data), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        valid = 1'b0;
        read_chk("f_rd3", 10'd3, 8'h83);
        read_chk("f_rd20", 10'd20, 8'h14);
        chk("f_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signal_capture.md
SIGNAL_CAPTURE -- requirements
Module: signal_capture

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, meaning the signed sample width.
REQ-002 The block SHALL have parameter NB_ADDR, default 10, meaning the buffer address width (depth 2^NB_ADDR).
REQ-003 The block SHALL have port i_clock  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_reset  input  1  meaning the reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_start  input  1  meaning a one-cycle request to begin a capture.
REQ-006 The block SHALL have port i_stop  input  1  meaning a one-cycle request to abort the capture early.
REQ-007 The block SHALL have port i_trig_mode  input  1  meaning 0 = immediate start, 1 = start on an upward zero crossing.
REQ-008 The block SHALL have port i_valid  input  1  meaning i_data holds a new sample this cycle.
REQ-009 The block SHALL have port i_data  input  NB_DATA  meaning the signed sample stream, for example the filter output.
REQ-010 The block SHALL have port i_rd_addr  input  NB_ADDR  meaning the readout address.
REQ-011 The block SHALL have port o_rd_data  output  NB_DATA  meaning the signed readout data.
REQ-012 The block SHALL have port o_busy  output  1  meaning the state is ARMED or CAPTURE.
REQ-013 The block SHALL have port o_done  output  1  meaning the state is DONE.
REQ-014 The block SHALL have port o_count  output  NB_ADDR+1  meaning the number of samples stored in the current or last capture.

Function
REQ-015 The FSM SHALL have four states: IDLE, ARMED, CAPTURE and DONE.
REQ-016 From IDLE or DONE, i_start SHALL clear o_count and move to CAPTURE if i_trig_mode=0, or to ARMED if i_trig_mode=1.
REQ-017 i_start SHALL be ignored in ARMED and CAPTURE.
REQ-018 In ARMED, a valid sample with a negative previous valid sample and a current value >= 0 SHALL move to CAPTURE, and that crossing sample SHALL be written at address 0.
REQ-019 The previous-sample register SHALL update on every i_valid in every state, and it SHALL be 0 after reset.
REQ-020 In CAPTURE, each i_valid SHALL write i_data to mem[o_count] and increment o_count in the same edge.
REQ-021 A sample arriving in the same cycle as i_start SHALL NOT be stored.
REQ-022 When the write takes o_count to 2^NB_ADDR, the FSM SHALL move to DONE on that edge, and later samples SHALL be dropped with no wrap-around.
REQ-023 i_stop in ARMED or CAPTURE SHALL move to DONE.
REQ-024 If i_stop and i_valid are both high in CAPTURE, the sample SHALL be written before entering DONE.
REQ-025 i_stop in IDLE or DONE SHALL be ignored.
REQ-026 If i_start and i_stop are both high in the same cycle, i_stop SHALL take priority in ARMED and CAPTURE, and i_start SHALL take priority in IDLE and DONE.
REQ-027 o_rd_data SHALL be registered with 1-cycle latency: o_rd_data(t+1) = mem[i_rd_addr(t)].
REQ-028 Readout SHALL be available in all states.
REQ-029 A simultaneous read and write to the same address SHALL return the old data (read-first).
REQ-030 o_busy, o_done and o_count SHALL be registered and change on the same edge as the state.

Reset
REQ-031 Assertion of i_reset SHALL immediately force the following: state IDLE, o_count=0, o_rd_data=0, o_busy=0, o_done=0 and previous sample=0.
REQ-032 Buffer memory contents SHALL NOT be reset, and reading after reset SHALL return the pre-reset contents.
REQ-033 Reset asserted mid-capture SHALL discard the capture state with no further writes.
REQ-034 Deassertion SHALL take effect at the next clock edge.

Structure
REQ-035 The state encoding (IDLE=0, ARMED=1, CAPTURE=2, DONE=3) and the NB_DATA/NB_ADDR defaults SHALL live in the shared signal-chain package, next to the signal generator constants.
REQ-036 Storage SHALL be a sub-module capture_bram: simple dual-port, one write port and one registered read port, read-first, inferable as block RAM.
REQ-037 The FSM, counter and trigger logic SHALL be in signal_capture.

Verification
REQ-038 Immediate full capture: reset, i_trig_mode=0, i_start pulse, then 1024 valid samples with i_data=addr[7:0] -> o_busy high 1 cycle after i_start; o_done high after the 1024th sample; o_count=1024; readout of addr 5 gives 0x05 one cycle later; a 1025th sample leaves addr 0 unchanged.
REQ-039 Early stop: start, 10 valid samples, then i_stop with i_valid and i_data=0x7F -> o_count=11, mem[10]=0x7F, o_done=1.
REQ-040 Zero-crossing trigger: i_trig_mode=1, stream -3,-1,2,5,-4 after start -> mem[0]=2, mem[1]=5, mem[2]=-4 (0xFC), o_count=3.
REQ-041 Start-cycle sample: i_start and i_valid together with i_data=0x11, next sample 0x22 -> mem[0]=0x22, o_count=1.
REQ-042 Reset mid-capture: i_reset low after 20 samples -> all outputs 0 and state IDLE within the same cycle; readout of addr 3 after release still returns the sample written before reset.
REQ-043 Restart from DONE: i_start in DONE -> o_count=0, o_done low and o_busy high on the next edge, and new samples overwrite from addr 0.
